input_debounce: RTL

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/input_debounce.sv | 95 +++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encodings and the default qualification length.
// Multi-key instances import this package so that they all agree on both.
package debounce_pkg;

  localparam int unsigned CNT_MAX_DEFAULT = 32'd1000000;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LO = ST_STABLE_LO,
    WAIT_HI   = ST_WAIT_HI,
    STABLE_HI = ST_STABLE_HI,
    WAIT_LO   = ST_WAIT_LO
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input.
// Both stages take a chosen level while in reset.
module sync_2ff #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage shift; only q is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= INIT_LEVEL;
      q      <= INIT_LEVEL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debouncer: synchronizes din, then accepts a new level only after CNT_MAX stable cycles.
// Produces registered single-cycle rise and fall pulses.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_MAX_DEFAULT,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(CNT_MAX);
  // The edge that enters a WAIT state is already the first stable cycle,
  // so a count of CNT_MAX-2 there means this edge completes the CNT_MAX-th cycle.
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(CNT_MAX - 32'd2);
  localparam state_e        RST_STATE  = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  logic          din_s;
  state_e        state_r;
  logic [CW-1:0] cnt_r;

  sync_2ff #(
    .INIT_LEVEL(INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (din_s)
  );

  // Qualification FSM with counter and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      cnt_r   <= {CW{1'b0}};
      dout    <= INIT_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state_r)
        STABLE_LO: begin
          if (din_s) begin
            state_r <= WAIT_HI;
            cnt_r   <= {CW{1'b0}};
          end
        end
        WAIT_HI: begin
          if (!din_s) begin
            state_r <= STABLE_LO;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CNT_ACCEPT) begin
            state_r <= STABLE_HI;
            cnt_r   <= {CW{1'b0}};
            dout    <= 1'b1;
            rise    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!din_s) begin
            state_r <= WAIT_LO;
            cnt_r   <= {CW{1'b0}};
          end
        end
        WAIT_LO: begin
          if (din_s) begin
            state_r <= STABLE_HI;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CNT_ACCEPT) begin
            state_r <= STABLE_LO;
            cnt_r   <= {CW{1'b0}};
            dout    <= 1'b0;
            fall    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= RST_STATE;
          cnt_r   <= {CW{1'b0}};
          dout    <= INIT_LEVEL;
        end
      endcase
    end
  end

endmodule
